mmio_ctrl: RTL and testbench

Parametrised memory-mapped I/O controller on the MIPS data bus, decoding the upper half of the 8-bit data address space (addr[7]=1). It exposes N debounced push-buttons with sticky press flags, a synchronised switch bank, and a multiplexed 7-segment display of up to 8 hex digits with a per-digit enable mask. It generalises the existing fixed 2-button/16-switch/8-digit decoder with configurable widths, debouncing, write-1-to-clear status and digit masking.

---
 rtl/mmio_pkg.sv | 57 +++++
 rtl/btn_debounce.sv | 53 +++++
 rtl/mmio_ctrl.sv | 128 ++++++++++++
 tb/tb_mmio_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared address map, register decode and 7-segment lookup for mmio_ctrl
package mmio_pkg;

    localparam logic [7:0] ADDR_STATUS   = 8'h80;
    localparam logic [7:0] ADDR_SWITCH   = 8'h84;
    localparam logic [7:0] ADDR_DISPLAY  = 8'h88;
    localparam logic [7:0] ADDR_DIGIT_EN = 8'h8C;

    typedef enum logic [2:0] {
        REG_STATUS,
        REG_SWITCH,
        REG_DISPLAY,
        REG_DIGIT_EN,
        REG_NONE
    } reg_idx_e;

    // Word address (addr[7:2]) to register; the byte offset never matters.
    function automatic reg_idx_e decode_addr(input logic [5:0] word_addr);
        reg_idx_e idx;
        idx = REG_NONE;
        if (word_addr[5]) begin
            case (word_addr[4:0])
                ADDR_STATUS[6:2]:   idx = REG_STATUS;
                ADDR_SWITCH[6:2]:   idx = REG_SWITCH;
                ADDR_DISPLAY[6:2]:  idx = REG_DISPLAY;
                ADDR_DIGIT_EN[6:2]: idx = REG_DIGIT_EN;
                default:            idx = REG_NONE;
            endcase
        end
        return idx;
    endfunction

    // Hex nibble to active-low segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] on;
        case (nib)
            4'h0: on = 7'h3F;
            4'h1: on = 7'h06;
            4'h2: on = 7'h5B;
            4'h3: on = 7'h4F;
            4'h4: on = 7'h66;
            4'h5: on = 7'h6D;
            4'h6: on = 7'h7D;
            4'h7: on = 7'h07;
            4'h8: on = 7'h7F;
            4'h9: on = 7'h6F;
            4'hA: on = 7'h77;
            4'hB: on = 7'h7C;
            4'hC: on = 7'h39;
            4'hD: on = 7'h5E;
            4'hE: on = 7'h79;
            default: on = 7'h71;
        endcase
        return ~on;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchroniser, debouncer and debounced rising-edge pulse
import mmio_pkg::*;

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             meta_q;
    logic             sync_q;
    logic             level_q, level_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing samples; flip the level once the run is long enough.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, debounce state and previous level for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= btn_in;
            sync_q  <= meta_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = level_q & ~prev_q;

endmodule

// File: rtl/mmio_ctrl.sv
// rtl/mmio_ctrl.sv - MMIO buttons/switches/7-segment controller on the upper half of the data bus
import mmio_pkg::*;

module mmio_ctrl #(
    parameter int NUM_BTNS        = 2,
    parameter int SW_WIDTH        = 16,
    parameter int NUM_DIGITS      = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_DIV        = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [7:0]            addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    input  logic [NUM_BTNS-1:0]   btn,
    input  logic [SW_WIDTH-1:0]   sw,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            a2g
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    reg_idx_e              sel;
    logic                  unused_addr_bits;
    logic [NUM_BTNS-1:0]   rise_vec;
    logic [NUM_BTNS-1:0]   status_q, status_d;
    logic [31:0]           display_q, display_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic [SW_WIDTH-1:0]   sw_meta_q, sw_sync_q;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  scan_tick;

    assign sel              = decode_addr(addr[7:2]);
    assign unused_addr_bits = ^addr[1:0];

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk   (clk),
            .reset (reset),
            .btn_in(btn[i]),
            .rise  (rise_vec[i])
        );
    end

    // CPU writes; a new press in the same cycle as a W1C keeps its flag.
    always_comb begin
        status_d   = status_q;
        display_d  = display_q;
        digit_en_d = digit_en_q;
        if (we) begin
            case (sel)
                REG_STATUS:   status_d   = status_q & ~wdata[NUM_BTNS-1:0];
                REG_DISPLAY:  display_d  = wdata;
                REG_DIGIT_EN: digit_en_d = wdata[NUM_DIGITS-1:0];
                default:      ;
            endcase
        end
        status_d = status_d | rise_vec;
    end

    // Scanner: on each prescaler wrap, step to the next digit and latch its drive.
    always_comb begin
        scan_tick = (presc_q == PRESC_W'(SCAN_DIV - 1));
        presc_d   = scan_tick ? '0 : presc_q + 1'b1;
        idx_d     = idx_q;
        an_d      = an_q;
        seg_d     = seg_q;
        if (scan_tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            if (digit_en_q[idx_d]) begin
                an_d  = ~(NUM_DIGITS'(1) << idx_d);
                seg_d = hex_to_seg(display_q[4*idx_d +: 4]);
            end else begin
                an_d  = '1;
                seg_d = 7'h7F;
            end
        end
    end

    // Read mux, combinational from the address and current register state.
    always_comb begin
        rdata = '0;
        case (sel)
            REG_STATUS:   rdata[NUM_BTNS-1:0]   = status_q;
            REG_SWITCH:   rdata[SW_WIDTH-1:0]   = sw_sync_q;
            REG_DISPLAY:  rdata                 = display_q;
            REG_DIGIT_EN: rdata[NUM_DIGITS-1:0] = digit_en_q;
            default:      rdata                 = '0;
        endcase
    end

    // Register, switch synchroniser and scanner state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            status_q   <= '0;
            display_q  <= '0;
            digit_en_q <= '1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            presc_q    <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= 7'h7F;
        end else begin
            status_q   <= status_d;
            display_q  <= display_d;
            digit_en_q <= digit_en_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an  = an_q;
    assign a2g = seg_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// tb/tb_mmio_ctrl.sv - self-checking bench for mmio_ctrl with a behavioural reference model
module tb_mmio_ctrl;

    localparam int NB = 2;
    localparam int SWW = 16;
    localparam int ND = 8;
    localparam int DB = 4;
    localparam int SD = 4;

    localparam logic [6:0] SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic           clk;
    logic           reset;
    logic           we;
    logic [7:0]     addr;
    logic [31:0]    wdata;
    logic [31:0]    rdata;
    logic [NB-1:0]  btn;
    logic [SWW-1:0] sw;
    logic [ND-1:0]  an;
    logic [6:0]     a2g;

    int checks = 0;
    int errors = 0;

    mmio_ctrl #(
        .NUM_BTNS(NB), .SW_WIDTH(SWW), .NUM_DIGITS(ND),
        .DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
        .btn(btn), .sw(sw), .an(an), .a2g(a2g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [NB-1:0]  m_b1, m_b2, m_lvl, m_pend, m_status;
    bit             m_hq [NB][$];
    logic [SWW-1:0] m_s1, m_swv;
    logic [31:0]    m_disp;
    logic [ND-1:0]  m_en, m_an;
    logic [6:0]     m_seg;
    int             m_cyc;

    always @(posedge clk) begin : model
        logic [NB-1:0] set_now, flip_up, ds, w1c;
        logic          all_diff;
        int            k;
        if (!reset) begin
            m_b1 = '0; m_b2 = '0; m_lvl = '0; m_pend = '0; m_status = '0;
            m_s1 = '0; m_swv = '0; m_disp = '0; m_en = '1; m_an = '1;
            m_seg = 7'h7F; m_cyc = 0;
            for (int i = 0; i < NB; i++) m_hq[i].delete();
        end else begin
            m_cyc++;
            if (m_cyc % SD == 0) begin
                k = (m_cyc / SD) % ND;
                if (m_en[k]) begin
                    m_an  = ~(ND'(1) << k);
                    m_seg = ~SEG_ON[m_disp[4*k +: 4]];
                end else begin
                    m_an  = '1;
                    m_seg = 7'h7F;
                end
            end
            set_now = m_pend;
            flip_up = '0;
            ds = m_b2; m_b2 = m_b1; m_b1 = btn;
            for (int i = 0; i < NB; i++) begin
                m_hq[i].push_back(ds[i]);
                while (m_hq[i].size() > DB) void'(m_hq[i].pop_front());
                if (m_hq[i].size() == DB) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < DB; j++)
                        if (m_hq[i][j] == m_lvl[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_lvl[i] = ~m_lvl[i];
                        if (m_lvl[i]) flip_up[i] = 1'b1;
                    end
                end
            end
            m_pend = flip_up;
            m_swv = m_s1; m_s1 = sw;
            w1c = '0;
            if (we && addr[7]) begin
                case (addr[6:2])
                    5'd0: w1c = wdata[NB-1:0];
                    5'd2: m_disp = wdata;
                    5'd3: m_en = wdata[ND-1:0];
                    default: ;
                endcase
            end
            m_status = (m_status & ~w1c) | set_now;
        end
    end

    function automatic logic [31:0] m_read(input logic [7:0] a);
        if (!a[7]) return 32'd0;
        case (a[6:2])
            5'd0: return 32'(m_status);
            5'd1: return 32'(m_swv);
            5'd2: return m_disp;
            5'd3: return 32'(m_en);
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an got %h want ff", an); end
        checks++; if (a2g !== 7'h7F) begin errors++; $display("FAIL reset_a2g got %h want 7f", a2g); end
        addr = 8'h80; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", rdata); end
        addr = 8'h88; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_display got %h want 0", rdata); end
        addr = 8'h8C; #1;
        checks++; if (rdata !== 32'hFF) begin errors++; $display("FAIL reset_digit_en got %h want ff", rdata); end
        reset = 1'b1;
    endtask

    task automatic test_debounce();
        logic [31:0] exp;
        btn[0] = 1'b1; step(); step();
        btn[0] = 1'b0; repeat (6) step();
        addr = 8'h80; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL glitch_ignored got %h want 0", rdata); end
        btn[0] = 1'b1;
        for (int c = 1; c <= DB + 3; c++) begin
            step();
            addr = 8'h80; #1;
            exp = (c >= DB + 3) ? 32'h1 : 32'h0;
            checks++;
            if (rdata !== exp) begin errors++; $display("FAIL debounce_c%0d got %h want %h", c, rdata, exp); end
            checks++;
            if (rdata !== m_read(8'h80)) begin errors++; $display("FAIL debounce_model_c%0d got %h want %h", c, rdata, m_read(8'h80)); end
        end
        do_write(8'h80, 32'h1);
        addr = 8'h80; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL w1c_clear got %h want 0", rdata); end
        btn[0] = 1'b0;
        repeat (DB + 4) step();
        addr = 8'h80; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL release_no_flag got %h want 0", rdata); end
    endtask

    task automatic test_w1c_collision();
        bit found = 1'b0;
        btn[1] = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (m_pend[1]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL collision_timeout got no rise want rise within 20 cycles");
        end else begin
            we = 1'b1; addr = 8'h80; wdata = 32'h2; #1;
            checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL read_old_during_write got %h want 0", rdata); end
            step();
            we = 1'b0; #1;
            checks++; if (rdata[1] !== 1'b1) begin errors++; $display("FAIL set_wins got %h want bit1 set", rdata); end
            checks++; if (rdata !== m_read(8'h80)) begin errors++; $display("FAIL set_wins_model got %h want %h", rdata, m_read(8'h80)); end
        end
        do_write(8'h80, 32'h2);
        addr = 8'h80; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL collision_clear got %h want 0", rdata); end
        btn[1] = 1'b0;
        repeat (DB + 4) step();
    endtask

    task automatic test_switch();
        sw = 16'hA5C3; addr = 8'h84;
        step(); #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL switch_1cyc got %h want 0", rdata); end
        step(); #1;
        checks++; if (rdata !== 32'h0000A5C3) begin errors++; $display("FAIL switch_2cyc got %h want a5c3", rdata); end
        do_write(8'h84, 32'hFFFFFFFF);
        addr = 8'h84; #1;
        checks++; if (rdata !== 32'h0000A5C3) begin errors++; $display("FAIL switch_ro got %h want a5c3", rdata); end
    endtask

    task automatic test_scan();
        bit seen0 = 0, seen_dis = 0, seen7 = 0;
        logic [ND-1:0] prev_an;
        do_write(8'h88, 32'h12345678);
        do_write(8'h8C, 32'hFD);
        prev_an = an;
        for (int c = 0; c < 3 * ND * SD; c++) begin
            step();
            checks++; if (an !== m_an) begin errors++; $display("FAIL scan_an c%0d got %h want %h", c, an, m_an); end
            checks++; if (a2g !== m_seg) begin errors++; $display("FAIL scan_a2g c%0d got %h want %h", c, a2g, m_seg); end
            if (an == 8'hFE && a2g == 7'h00) seen0 = 1;
            if (an == 8'h7F && a2g == 7'h79) seen7 = 1;
            if (prev_an == 8'hFE && an != 8'hFE) begin
                if (an == 8'hFF && a2g == 7'h7F) seen_dis = 1;
            end
            if (prev_an == 8'h7F && an != 8'h7F) begin
                checks++; if (an !== 8'hFE) begin errors++; $display("FAIL scan_wrap got %h want fe", an); end
            end
            prev_an = an;
        end
        checks++; if (!seen0) begin errors++; $display("FAIL scan_digit0 got not seen want an=fe a2g=00"); end
        checks++; if (!seen_dis) begin errors++; $display("FAIL scan_disabled got not seen want an=ff a2g=7f"); end
        checks++; if (!seen7) begin errors++; $display("FAIL scan_digit7 got not seen want an=7f a2g=79"); end
    endtask

    task automatic test_unmapped();
        addr = 8'h90; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL read_90 got %h want 0", rdata); end
        addr = 8'h04; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL read_04 got %h want 0", rdata); end
        addr = 8'h08; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL read_08 got %h want 0", rdata); end
        do_write(8'h90, 32'hFFFFFFFF);
        do_write(8'h04, 32'hFFFFFFFF);
        do_write(8'h08, 32'h0);
        do_write(8'h0C, 32'h0);
        addr = 8'h88; #1;
        checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL unmapped_display got %h want 12345678", rdata); end
        addr = 8'h8C; #1;
        checks++; if (rdata !== 32'hFD) begin errors++; $display("FAIL unmapped_digit_en got %h want fd", rdata); end
    endtask

    task automatic test_random();
        logic [7:0] alist [8] = '{8'h80, 8'h84, 8'h88, 8'h8C, 8'h90, 8'h04, 8'h08, 8'h00};
        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(0, 3) == 0);
            addr = alist[$urandom_range(0, 7)];
            if (addr == 8'h00) addr = 8'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 39) == 0) btn = NB'($urandom);
            if ($urandom_range(0, 9) == 0) sw = SWW'($urandom);
            #1;
            checks++; if (rdata !== m_read(addr)) begin errors++; $display("FAIL rand_rdata n%0d addr %h got %h want %h", n, addr, rdata, m_read(addr)); end
            step();
            checks++; if (an !== m_an) begin errors++; $display("FAIL rand_an n%0d got %h want %h", n, an, m_an); end
            checks++; if (a2g !== m_seg) begin errors++; $display("FAIL rand_a2g n%0d got %h want %h", n, a2g, m_seg); end
        end
        we = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        btn = '0;
        repeat (DB + 4) step();
        btn[0] = 1'b1;
        repeat (4) step();
        wdata = 32'hDEADBEEF;
        reset = 1'b0;
        step();
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL midreset_an got %h want ff", an); end
        checks++; if (a2g !== 7'h7F) begin errors++; $display("FAIL midreset_a2g got %h want 7f", a2g); end
        addr = 8'h80; #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL midreset_status got %h want 0", rdata); end
        addr = 8'h8C; #1;
        checks++; if (rdata !== 32'hFF) begin errors++; $display("FAIL midreset_digit_en got %h want ff", rdata); end
        reset = 1'b1;
        for (int c = 1; c <= DB + 3; c++) begin
            step();
            addr = 8'h80; #1;
            exp = (c >= DB + 3) ? 32'h1 : 32'h0;
            checks++; if (rdata !== exp) begin errors++; $display("FAIL restart_debounce_c%0d got %h want %h", c, rdata, exp); end
            if (c == SD - 1) begin
                checks++; if (an !== 8'hFF) begin errors++; $display("FAIL pre_tick_an got %h want ff", an); end
            end
            if (c == SD) begin
                checks++; if (an !== 8'hFD || a2g !== 7'h40) begin errors++; $display("FAIL first_tick got an %h a2g %h want fd 40", an, a2g); end
            end
        end
        btn = '0;
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; addr = 8'h0; wdata = 32'h0; btn = '0; sw = '0;
        step();
        test_reset();
        test_debounce();
        test_w1c_collision();
        test_switch();
        test_scan();
        test_unmapped();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
